// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
//   Shared definitions for the ALU unit arbiter:
//     - unit select codes carried in FUN[3:2]
//     - FSM state encoding for the arbiter top level
//     - helper that turns a unit select code into the one-hot enable vector
//   Enable vector bit order: [0] arith, [1] logic, [2] cmp, [3] shift.
// ---------------------------------------------------------------------------
package alu_arb_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam int unsigned NUM_UNITS = 4;
    localparam int unsigned STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_e;

    function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [1:0] unit);
        logic [NUM_UNITS-1:0] oh;
        oh = '0;
        unique case (unit)
            UNIT_ARITH: oh = 4'b0001;
            UNIT_LOGIC: oh = 4'b0010;
            UNIT_CMP:   oh = 4'b0100;
            UNIT_SHIFT: oh = 4'b1000;
            default:    oh = '0;
        endcase
        return oh;
    endfunction

    // Saturating increment for the optional grant statistics.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// alu_rr_arbiter2
//   Two-way round-robin grant logic with a LAST pointer.
//   When both requests are present the requester that did not win last time
//   is granted; a lone request is granted regardless of LAST. LAST is updated
//   to the winner on every grant and resets to 1 so requester 0 wins first.
//
//   Ports:
//     clk_i     clock
//     rst_i     synchronous, active-high reset
//     en_i      grants may be issued this cycle (arbiter owner is idle)
//     req0_i    requester 0 valid
//     req1_i    requester 1 valid
//     gnt0_o    requester 0 granted (combinational)
//     gnt1_o    requester 1 granted (combinational)
//     gnt_id_o  index of the granted requester (meaningful with a grant)
// ---------------------------------------------------------------------------
module alu_rr_arbiter2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic gnt_id_o
);

    logic last_q, last_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (en_i) begin
            if (req0_i && req1_i) begin
                // Contention: the one that was not served last goes now.
                gnt0_o = last_q;
                gnt1_o = ~last_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
        gnt_id_o = gnt1_o;
    end

    always_comb begin
        last_d = last_q;
        if (gnt0_o) begin
            last_d = 1'b0;
        end else if (gnt1_o) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_unit_arbiter.sv
// ---------------------------------------------------------------------------
// alu_unit_arbiter
//   Shares one set of ALU function units (arith, logic, cmp, shift) between
//   two requesters. A round-robin grant in IDLE latches the winner's command;
//   ISSUE pulses the selected unit enable with the operands on the shared bus;
//   WAIT captures the selected unit's registered output; RESP presents the
//   result on a valid/ready channel. At most one command is in flight.
//
//   Optional build macro: ALU_ARB_STATS_EN adds saturating 16-bit grant
//   counters GRANT_CNT0/GRANT_CNT1. Without it those ports do not exist.
//
//   Ports:
//     CLK, RST                  clock, synchronous active-high reset
//     REQx_VALID / REQx_READY   command handshake per requester (READY is a
//                               combinational grant, high only in IDLE)
//     REQx_A, REQx_B, REQx_FUN  operands and op ([3:2] unit, [1:0] function)
//     RSP_VALID / RSP_READY     response handshake
//     RSP_ID, RSP_DATA          owning requester and captured result
//     BUSY                      state is not IDLE
//     ALU_A, ALU_B, ALU_FUN     shared operand bus to the units
//     *_Enable                  one-hot unit enables, high in ISSUE only
//     *_OUT                     registered unit outputs
//     GRANT_CNT0/1              grant statistics (ALU_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module alu_unit_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    input  logic [3:0]       REQ0_FUN,

    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    input  logic [3:0]       REQ1_FUN,

    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_ID,
    output logic [WIDTH-1:0] RSP_DATA,

    output logic             BUSY,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0]      GRANT_CNT0,
    output logic [15:0]      GRANT_CNT1,
`endif

    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [1:0]       ALU_FUN,
    output logic             Arith_Enable,
    output logic             Logic_Enable,
    output logic             CMP_Enable,
    output logic             SHIFT_Enable,

    input  logic [WIDTH-1:0] Arith_OUT,
    input  logic [WIDTH-1:0] Logic_OUT,
    input  logic [WIDTH-1:0] CMP_OUT,
    input  logic [WIDTH-1:0] SHIFT_OUT
);

    arb_state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       fun_q, fun_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             gnt0, gnt1, gnt_id, grant;
    logic             arb_en;
    logic [WIDTH-1:0] unit_out;
    logic [3:0]       unit_en;

    // A reset cycle never accepts a command: the grant would be dropped anyway.
    assign arb_en = (state_q == IDLE) && !RST;

    alu_rr_arbiter2 u_rr (
        .clk_i    (CLK),
        .rst_i    (RST),
        .en_i     (arb_en),
        .req0_i   (REQ0_VALID),
        .req1_i   (REQ1_VALID),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1),
        .gnt_id_o (gnt_id)
    );

    assign grant = gnt0 | gnt1;

    // Result mux: selected by the latched unit field, sampled during WAIT.
    always_comb begin
        unit_out = Arith_OUT;
        unique case (fun_q[3:2])
            UNIT_ARITH: unit_out = Arith_OUT;
            UNIT_LOGIC: unit_out = Logic_OUT;
            UNIT_CMP:   unit_out = CMP_OUT;
            UNIT_SHIFT: unit_out = SHIFT_OUT;
            default:    unit_out = Arith_OUT;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        id_d    = id_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    // The latch doubles as the operand bus register, so the
                    // bus changes only on a grant and holds otherwise.
                    a_d     = gnt_id ? REQ1_A   : REQ0_A;
                    b_d     = gnt_id ? REQ1_B   : REQ0_B;
                    fun_d   = gnt_id ? REQ1_FUN : REQ0_FUN;
                    id_d    = gnt_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                data_d  = unit_out;
                state_d = RESP;
            end
            RESP: begin
                if (RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    assign unit_en = (state_q == ISSUE) ? unit_onehot(fun_q[3:2]) : 4'b0000;

    assign Arith_Enable = unit_en[0];
    assign Logic_Enable = unit_en[1];
    assign CMP_Enable   = unit_en[2];
    assign SHIFT_Enable = unit_en[3];

    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign ALU_FUN    = fun_q[1:0];

    assign REQ0_READY = gnt0;
    assign REQ1_READY = gnt1;
    assign RSP_VALID  = (state_q == RESP);
    assign RSP_ID     = id_q;
    assign RSP_DATA   = data_q;
    assign BUSY       = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q, cnt0_d;
    logic [STAT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0) begin
            cnt0_d = sat_inc(cnt0_q);
        end
        if (gnt1) begin
            cnt1_d = sat_inc(cnt1_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign GRANT_CNT0 = cnt0_q;
    assign GRANT_CNT1 = cnt1_q;
`endif

endmodule
